// File: rtl/z_core_alu_ctrl.sv
// z_core_alu_ctrl: ALU control decoder for the Z-Core RV32I datapath.
// Maps opcode/funct3/funct7 to a 4-bit ALU operation code and registers it
// so that it lines up with the register-file read stage one cycle later.
// Optional macro Z_CORE_ALU_CTRL_ILLEGAL_EN adds the registered alu_illegal
// flag, which is 1 exactly when the registered code is INVALID (4'hF).
// Timing: inputs sampled on rising edge N appear on the outputs after edge N.
// Reset (rstn low) forces ADD / not-illegal immediately and holds while low.
module z_core_alu_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic [6:0] alu_op,
  input  logic [2:0] alu_funct3,
  input  logic [6:0] alu_funct7,
`ifdef Z_CORE_ALU_CTRL_ILLEGAL_EN
  output logic       alu_illegal,
`endif
  output logic [3:0] alu_inst_type
);

  // ALU operation codes
  localparam logic [3:0] ALU_ADD     = 4'd0;
  localparam logic [3:0] ALU_SUB     = 4'd1;
  localparam logic [3:0] ALU_SLL     = 4'd2;
  localparam logic [3:0] ALU_SLT     = 4'd3;
  localparam logic [3:0] ALU_SLTU    = 4'd4;
  localparam logic [3:0] ALU_XOR     = 4'd5;
  localparam logic [3:0] ALU_SRL     = 4'd6;
  localparam logic [3:0] ALU_SRA     = 4'd7;
  localparam logic [3:0] ALU_OR      = 4'd8;
  localparam logic [3:0] ALU_AND     = 4'd9;
  localparam logic [3:0] ALU_INVALID = 4'hF;

  // RV32I major opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [3:0] inst_type_d;
  logic [3:0] inst_type_q;
  logic       f7_zero;
  logic       f7_alt;

  // Decode the current instruction fields into an ALU operation code.
  // funct7 is only consulted on paths that need it, so an X there on
  // encodings that ignore it never reaches the output register.
  always_comb begin
    inst_type_d = ALU_INVALID;
    f7_zero     = (alu_funct7 == F7_ZERO);
    f7_alt      = (alu_funct7 == F7_ALT);
    case (alu_op)
      OPC_R: begin
        case (alu_funct3)
          3'b000: begin
            if (f7_zero)     inst_type_d = ALU_ADD;
            else if (f7_alt) inst_type_d = ALU_SUB;
          end
          3'b001: if (f7_zero) inst_type_d = ALU_SLL;
          3'b010: if (f7_zero) inst_type_d = ALU_SLT;
          3'b011: if (f7_zero) inst_type_d = ALU_SLTU;
          3'b100: if (f7_zero) inst_type_d = ALU_XOR;
          3'b101: begin
            if (f7_zero)     inst_type_d = ALU_SRL;
            else if (f7_alt) inst_type_d = ALU_SRA;
          end
          3'b110: if (f7_zero) inst_type_d = ALU_OR;
          3'b111: if (f7_zero) inst_type_d = ALU_AND;
          default: inst_type_d = ALU_INVALID;
        endcase
      end
      OPC_I: begin
        case (alu_funct3)
          3'b000: inst_type_d = ALU_ADD;
          3'b001: if (f7_zero) inst_type_d = ALU_SLL;
          3'b010: inst_type_d = ALU_SLT;
          3'b011: inst_type_d = ALU_SLTU;
          3'b100: inst_type_d = ALU_XOR;
          3'b101: begin
            if (f7_zero)     inst_type_d = ALU_SRL;
            else if (f7_alt) inst_type_d = ALU_SRA;
          end
          3'b110: inst_type_d = ALU_OR;
          3'b111: inst_type_d = ALU_AND;
          default: inst_type_d = ALU_INVALID;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC:
        inst_type_d = ALU_ADD;
      OPC_BRANCH: begin
        case (alu_funct3)
          3'b000, 3'b001: inst_type_d = ALU_SUB;
          3'b100, 3'b101: inst_type_d = ALU_SLT;
          3'b110, 3'b111: inst_type_d = ALU_SLTU;
          default:        inst_type_d = ALU_INVALID;
        endcase
      end
      default: inst_type_d = ALU_INVALID;
    endcase
  end

  // Capture the decoded code every cycle; async reset clears to ADD.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) inst_type_q <= ALU_ADD;
    else       inst_type_q <= inst_type_d;
  end

  assign alu_inst_type = inst_type_q;

`ifdef Z_CORE_ALU_CTRL_ILLEGAL_EN
  logic illegal_d;
  logic illegal_q;

  // Illegal flag is derived from the same decode so it always matches the code.
  always_comb begin
    illegal_d = (inst_type_d == ALU_INVALID);
  end

  // Register the flag alongside the code; async reset clears it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign alu_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_z_core_alu_ctrl.sv
// tb_z_core_alu_ctrl: directed scoreboard bench for z_core_alu_ctrl.
// Expected codes are pushed to exp_q when a step is driven and popped and
// compared when the registered output becomes visible one edge later.
module tb_z_core_alu_ctrl;

  logic       clk;
  logic       rstn;
  logic [6:0] alu_op;
  logic [2:0] alu_funct3;
  logic [6:0] alu_funct7;
  logic [3:0] alu_inst_type;
`ifdef Z_CORE_ALU_CTRL_ILLEGAL_EN
  logic       alu_illegal;
`endif

  logic [3:0] exp_q[$];
  int checks;
  int errors;

  z_core_alu_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .alu_op        (alu_op),
    .alu_funct3    (alu_funct3),
    .alu_funct7    (alu_funct7),
`ifdef Z_CORE_ALU_CTRL_ILLEGAL_EN
    .alu_illegal   (alu_illegal),
`endif
    .alu_inst_type (alu_inst_type)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare current outputs against an expected code
  task automatic check_out(input string tag, input logic [3:0] exp);
    checks++;
    assert (alu_inst_type === exp) else begin
      errors++;
      $error("FAIL %s: alu_inst_type=%h expected %h", tag, alu_inst_type, exp);
    end
`ifdef Z_CORE_ALU_CTRL_ILLEGAL_EN
    checks++;
    assert (alu_illegal === (exp == 4'hF)) else begin
      errors++;
      $error("FAIL %s_illegal: alu_illegal=%b expected %b", tag, alu_illegal, (exp == 4'hF));
    end
`endif
  endtask

  // driver: apply fields, push expectation, wait one edge, pop and compare
  task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [3:0] exp);
    logic [3:0] e;
    alu_op     = op;
    alu_funct3 = f3;
    alu_funct7 = f7;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue: scoreboard empty, expected 1 entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_out(tag, e);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rstn       = 1'b0;
    alu_op     = 7'b0110011;
    alu_funct3 = 3'b000;
    alu_funct7 = 7'b0100000;

    // power-on reset: outputs at reset values, held across edges
    #2;
    check_out("por", 4'd0);
    @(posedge clk); #1;
    check_out("por_hold", 4'd0);
    @(negedge clk);
    rstn = 1'b1;

    // first capture happens on first edge with rstn high (SUB pending)
    step("first_capture_sub", 7'b0110011, 3'b000, 7'b0100000, 4'd1);

    // R-type
    step("r_add",  7'b0110011, 3'b000, 7'b0000000, 4'd0);
    step("r_sub",  7'b0110011, 3'b000, 7'b0100000, 4'd1);
    step("r_sra",  7'b0110011, 3'b101, 7'b0100000, 4'd7);
    step("r_srl",  7'b0110011, 3'b101, 7'b0000000, 4'd6);
    step("r_and",  7'b0110011, 3'b111, 7'b0000000, 4'd9);
    step("r_or",   7'b0110011, 3'b110, 7'b0000000, 4'd8);
    step("r_xor",  7'b0110011, 3'b100, 7'b0000000, 4'd5);
    step("r_sltu", 7'b0110011, 3'b011, 7'b0000000, 4'd4);
    step("r_bad_f7", 7'b0110011, 3'b000, 7'b0000001, 4'hF);

    // I-type
    step("i_add_x",  7'b0010011, 3'b000, 7'bxxxxxxx, 4'd0);
    step("i_slt_x",  7'b0010011, 3'b010, 7'bxxxxxxx, 4'd3);
    step("i_slli",   7'b0010011, 3'b001, 7'b0000000, 4'd2);
    step("i_srai",   7'b0010011, 3'b101, 7'b0100000, 4'd7);
    step("i_slli_bad", 7'b0010011, 3'b001, 7'b0100000, 4'hF);
    step("i_and_f7", 7'b0010011, 3'b111, 7'b1111111, 4'd9);

    // branch / memory / jumps
    step("br_bltu", 7'b1100011, 3'b110, 7'b0000000, 4'd4);
    step("br_blt",  7'b1100011, 3'b100, 7'b0000000, 4'd3);
    step("br_bne",  7'b1100011, 3'b001, 7'b0000000, 4'd1);
    step("br_bad",  7'b1100011, 3'b010, 7'b0000000, 4'hF);
    for (int i = 0; i < 4; i++) begin
      step("load_any", 7'b0000011, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), 4'd0);
    end
    step("store", 7'b0100011, 3'b010, 7'b1010101, 4'd0);
    step("jal",   7'b1101111, 3'b111, 7'b1111111, 4'd0);
    step("lui",   7'b0110111, 3'b101, 7'b0100000, 4'd0);

    // invalid encodings
    step("inv_opc",   7'b1111111, 3'b111, 7'b1111111, 4'hF);
    step("inv_r_sll", 7'b0110011, 3'b001, 7'b0100000, 4'hF);

    // back-to-back ADD/SUB/SLL
    step("b2b_add", 7'b0110011, 3'b000, 7'b0000000, 4'd0);
    step("b2b_sub", 7'b0110011, 3'b000, 7'b0100000, 4'd1);
    step("b2b_sll", 7'b0110011, 3'b001, 7'b0000000, 4'd2);

    // get a non-reset value on the output, then reset mid-cycle
    step("pre_rst_and", 7'b0110011, 3'b111, 7'b0000000, 4'd9);
    alu_op     = 7'b1111111;
    alu_funct3 = 3'b111;
    alu_funct7 = 7'b1111111;
    exp_q.push_back(4'hF);
    #2;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check_out("rst_async", 4'd0);
    @(posedge clk); #1;
    check_out("rst_hold1", 4'd0);
    @(posedge clk); #1;
    check_out("rst_hold2", 4'd0);
    @(negedge clk);
    rstn = 1'b1;
    step("post_rst_inv", 7'b1111111, 3'b111, 7'b1111111, 4'hF);
    step("post_rst_sra", 7'b0110011, 3'b101, 7'b0100000, 4'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
